// File: rtl/punt_responder.sv
// Service-side responder for punted CPU cycles: RTC file, joystick/button reads, clockport forwarding.
// Optional build macro CP_TIMEOUT_EN adds a forced-completion timeout to the clockport wait.
module punt_responder #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned CP_TIMEOUT   = 255
) (
  input  logic        CLKCPU_A,
  input  logic        RESET_N,
  input  logic        REQ_RTC,
  input  logic        REQ_JOY,
  input  logic        REQ_BTN,
  input  logic        REQ_CP,
  input  logic [7:0]  A,
  input  logic        RW,
  input  logic [7:0]  DIN,
  input  logic [15:0] JOY0,
  input  logic [15:0] JOY1,
  input  logic [7:0]  BTN,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        ACK,
  output logic        CP_REQ,
  output logic        CP_RW,
  output logic [7:0]  CP_ADDR,
  output logic [7:0]  CP_WDATA,
  input  logic [7:0]  CP_RDATA,
  input  logic        CP_DONE,
  output logic        ERR,
  input  logic        ERR_CLR
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_CP_WAIT = 3'd2,
    ST_SETUP   = 3'd3,
    ST_ACKED   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_RTC = 2'd0,
    CLS_JOY = 2'd1,
    CLS_BTN = 2'd2,
    CLS_CP  = 2'd3
  } cls_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || CP_TIMEOUT < 1 || CP_TIMEOUT > 255) begin : g_bad_param
    $error("punt_responder: parameter out of range");
  end

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, prio_s;
  logic [3:0]  req_s, req_q;
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  din_q, din_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        ack_q, ack_d;
  logic        cp_req_q, cp_req_d;
  logic        cp_rw_q, cp_rw_d;
  logic [7:0]  cp_addr_q, cp_addr_d;
  logic [7:0]  cp_wdata_q, cp_wdata_d;
  logic        err_q, err_d;
  logic        err_set_s;
  logic        multi_s;
  logic        active_s;
  logic        rtc_we_s;
  logic [15:0] joy_word_s;
  logic [7:0]  rd_data_s;
  logic [7:0]  rtc_q [16];
  logic [7:0]  rtc_d [16];
`ifdef CP_TIMEOUT_EN
  localparam logic [7:0] CP_LIMIT = 8'(CP_TIMEOUT - 1);
  logic [7:0]  cp_cnt_q, cp_cnt_d;
`endif

  // Bit index of req_s matches the cls_t encoding so the active class can index it directly.
  assign req_s    = {REQ_CP, REQ_BTN, REQ_JOY, REQ_RTC};
  assign active_s = req_s[cls_q];
  assign multi_s  = (req_q & (req_q - 4'd1)) != 4'd0;

  always_comb begin
    if (req_q[0]) begin
      prio_s = CLS_RTC;
    end else if (req_q[1]) begin
      prio_s = CLS_JOY;
    end else if (req_q[2]) begin
      prio_s = CLS_BTN;
    end else begin
      prio_s = CLS_CP;
    end
  end

  always_comb begin
    joy_word_s = addr_q[1] ? JOY1 : JOY0;
    case (cls_q)
      CLS_RTC: rd_data_s = rtc_q[addr_q[5:2]];
      CLS_JOY: rd_data_s = addr_q[0] ? joy_word_s[7:0] : joy_word_s[15:8];
      CLS_BTN: rd_data_s = BTN;
      default: rd_data_s = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    cp_rw_d    = cp_rw_q;
    cp_addr_d  = cp_addr_q;
    cp_wdata_d = cp_wdata_q;
    err_set_s  = 1'b0;
    rtc_we_s   = 1'b0;
`ifdef CP_TIMEOUT_EN
    cp_cnt_d   = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Level check: requests that rose during RELEASE are still taken here if held.
        if (req_q != 4'd0) begin
          state_d   = ST_DECODE;
          cls_d     = prio_s;
          addr_d    = A;
          rw_d      = RW;
          din_d     = DIN;
          err_set_s = multi_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        cnt_d = 4'd0;
        if (!active_s) begin
          state_d   = ST_RELEASE;
          err_set_s = 1'b1;
        end else if (cls_q == CLS_CP) begin
          state_d    = ST_CP_WAIT;
          cp_rw_d    = rw_q;
          cp_addr_d  = addr_q;
          cp_wdata_d = din_q;
        end else begin
          state_d = ST_SETUP;
          if (rw_q) begin
            dout_d = rd_data_s;
          end else begin
            rtc_we_s = (cls_q == CLS_RTC);
          end
        end
      end
      ST_CP_WAIT: begin
        cnt_d = 4'd0;
        if (!active_s) begin
          state_d   = ST_RELEASE;
          err_set_s = 1'b1;
        end else if (CP_DONE) begin
          state_d = ST_SETUP;
          if (rw_q) begin
            dout_d = CP_RDATA;
          end else begin
            dout_d = dout_q;
          end
        end
`ifdef CP_TIMEOUT_EN
        else if (cp_cnt_q == CP_LIMIT) begin
          state_d   = ST_SETUP;
          err_set_s = 1'b1;
          if (rw_q) begin
            dout_d = 8'hFF;
          end else begin
            dout_d = dout_q;
          end
        end else begin
          cp_cnt_d = cp_cnt_q + 8'd1;
        end
`else
        else begin
          state_d = ST_CP_WAIT;
        end
`endif
      end
      ST_SETUP: begin
        if (!active_s) begin
          state_d   = ST_RELEASE;
          err_set_s = 1'b1;
          cnt_d     = 4'd0;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = ST_ACKED;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACKED: begin
        cnt_d = 4'd0;
        if (req_s == 4'd0) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_ACKED;
        end
      end
      ST_RELEASE: begin
        // Two low cycles so the requester's two-stage edge detector sees a clean low.
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d    = (state_d == ST_ACKED);
    doe_d    = rw_d && ((state_d == ST_SETUP) || (state_d == ST_ACKED));
    cp_req_d = (state_d == ST_CP_WAIT);
    if ((state_d == ST_RELEASE) || (state_d == ST_IDLE)) begin
      dout_d = 8'h00;
    end else begin
      dout_d = dout_d;
    end

    if (ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | err_set_s;
    end
  end

  always_comb begin
    rtc_d = rtc_q;
    if (rtc_we_s) begin
      rtc_d[addr_q[5:2]] = din_q;
    end else begin
      rtc_d = rtc_q;
    end
  end

  always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cls_q      <= CLS_RTC;
      req_q      <= 4'd0;
      addr_q     <= 8'h00;
      rw_q       <= 1'b0;
      din_q      <= 8'h00;
      cnt_q      <= 4'd0;
      dout_q     <= 8'h00;
      doe_q      <= 1'b0;
      ack_q      <= 1'b0;
      cp_req_q   <= 1'b0;
      cp_rw_q    <= 1'b0;
      cp_addr_q  <= 8'h00;
      cp_wdata_q <= 8'h00;
      err_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rtc_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      req_q      <= req_s;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      ack_q      <= ack_d;
      cp_req_q   <= cp_req_d;
      cp_rw_q    <= cp_rw_d;
      cp_addr_q  <= cp_addr_d;
      cp_wdata_q <= cp_wdata_d;
      err_q      <= err_d;
      for (int i = 0; i < 16; i++) begin
        rtc_q[i] <= rtc_d[i];
      end
    end
  end

`ifdef CP_TIMEOUT_EN
  always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
    if (!RESET_N) begin
      cp_cnt_q <= 8'd0;
    end else begin
      cp_cnt_q <= cp_cnt_d;
    end
  end
`endif

  assign DOUT     = dout_q;
  assign DOE      = doe_q;
  assign ACK      = ack_q;
  assign CP_REQ   = cp_req_q;
  assign CP_RW    = cp_rw_q;
  assign CP_ADDR  = cp_addr_q;
  assign CP_WDATA = cp_wdata_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_punt_responder.sv
// Directed self-checking bench for punt_responder (default build, default parameters).
module tb_punt_responder;

  logic        CLKCPU_A;
  logic        RESET_N;
  logic        REQ_RTC, REQ_JOY, REQ_BTN, REQ_CP;
  logic [7:0]  A;
  logic        RW;
  logic [7:0]  DIN;
  logic [15:0] JOY0, JOY1;
  logic [7:0]  BTN;
  logic [7:0]  DOUT;
  logic        DOE, ACK, CP_REQ, CP_RW;
  logic [7:0]  CP_ADDR, CP_WDATA, CP_RDATA;
  logic        CP_DONE, ERR, ERR_CLR;

  int n_tests = 0;
  int n_fail  = 0;

  punt_responder dut (
    .CLKCPU_A(CLKCPU_A), .RESET_N(RESET_N),
    .REQ_RTC(REQ_RTC), .REQ_JOY(REQ_JOY), .REQ_BTN(REQ_BTN), .REQ_CP(REQ_CP),
    .A(A), .RW(RW), .DIN(DIN), .JOY0(JOY0), .JOY1(JOY1), .BTN(BTN),
    .DOUT(DOUT), .DOE(DOE), .ACK(ACK),
    .CP_REQ(CP_REQ), .CP_RW(CP_RW), .CP_ADDR(CP_ADDR), .CP_WDATA(CP_WDATA),
    .CP_RDATA(CP_RDATA), .CP_DONE(CP_DONE), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  initial CLKCPU_A = 1'b0;
  always #5 CLKCPU_A = ~CLKCPU_A;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKCPU_A);
    #1;
  endtask

  task automatic set_req(input logic [3:0] mask);
    {REQ_CP, REQ_BTN, REQ_JOY, REQ_RTC} = mask;
  endtask

  // Full handshake: DOUT valid 2 edges after the registered edge, ACK 4 edges after it.
  task automatic do_cycle(input logic [3:0] mask, input logic [7:0] addr, input logic rw,
                          input logic [7:0] wdat, input logic [7:0] exp, input string tag);
    A = addr; RW = rw; DIN = wdat;
    set_req(mask);
    tick(); tick(); tick();
    check_eq({tag, "_doe"}, {7'd0, DOE}, {7'd0, rw});
    check_eq({tag, "_dout"}, DOUT, exp);
    check_eq({tag, "_ack_early"}, {7'd0, ACK}, 8'd0);
    tick();
    check_eq({tag, "_ack_e3"}, {7'd0, ACK}, 8'd0);
    tick();
    check_eq({tag, "_ack"}, {7'd0, ACK}, 8'd1);
    check_eq({tag, "_dout_held"}, DOUT, exp);
    set_req(4'd0);
    tick();
    check_eq({tag, "_ack_fall"}, {7'd0, ACK}, 8'd0);
    check_eq({tag, "_doe_fall"}, {7'd0, DOE}, 8'd0);
    tick(); tick();
  endtask

  initial begin
    RESET_N = 1'b0; set_req(4'd0);
    A = 8'h00; RW = 1'b0; DIN = 8'h00; JOY0 = 16'h0000; JOY1 = 16'h0000; BTN = 8'h00;
    CP_RDATA = 8'h00; CP_DONE = 1'b0; ERR_CLR = 1'b0;
    tick(); tick();
    check_eq("rst_dout", DOUT, 8'h00);
    check_eq("rst_doe", {7'd0, DOE}, 8'd0);
    check_eq("rst_ack", {7'd0, ACK}, 8'd0);
    check_eq("rst_cpreq", {7'd0, CP_REQ}, 8'd0);
    check_eq("rst_err", {7'd0, ERR}, 8'd0);
    RESET_N = 1'b1;
    tick();

    do_cycle(4'b0001, 8'h14, 1'b0, 8'h5A, 8'h00, "rtc_wr");
    do_cycle(4'b0001, 8'h14, 1'b1, 8'h00, 8'h5A, "rtc_rd");
    do_cycle(4'b0001, 8'h20, 1'b1, 8'h00, 8'h00, "rtc_rd_other");
    JOY1 = 16'h1234; JOY0 = 16'hABCD; BTN = 8'h96;
    do_cycle(4'b0010, 8'h02, 1'b1, 8'h00, 8'h12, "joy1_hi");
    do_cycle(4'b0010, 8'h03, 1'b1, 8'h00, 8'h34, "joy1_lo");
    do_cycle(4'b0010, 8'h01, 1'b1, 8'h00, 8'hCD, "joy0_lo");
    do_cycle(4'b0100, 8'h00, 1'b1, 8'h00, 8'h96, "btn");
    check_eq("err_clean", {7'd0, ERR}, 8'd0);

    // Clockport read, CP_DONE sampled 5 edges after CP_REQ rises.
    A = 8'h47; RW = 1'b1; set_req(4'b1000);
    tick(); tick(); tick();
    check_eq("cp_req_up", {7'd0, CP_REQ}, 8'd1);
    check_eq("cp_addr", CP_ADDR, 8'h47);
    check_eq("cp_rw", {7'd0, CP_RW}, 8'd1);
    tick(); tick(); tick(); tick();
    check_eq("cp_req_wait", {7'd0, CP_REQ}, 8'd1);
    check_eq("cp_ack_wait", {7'd0, ACK}, 8'd0);
    CP_DONE = 1'b1; CP_RDATA = 8'hC3;
    tick();
    CP_DONE = 1'b0; CP_RDATA = 8'h00;
    check_eq("cp_req_drop", {7'd0, CP_REQ}, 8'd0);
    check_eq("cp_dout", DOUT, 8'hC3);
    check_eq("cp_doe", {7'd0, DOE}, 8'd1);
    tick();
    check_eq("cp_ack_e1", {7'd0, ACK}, 8'd0);
    tick();
    check_eq("cp_ack", {7'd0, ACK}, 8'd1);
    check_eq("cp_dout_held", DOUT, 8'hC3);
    set_req(4'd0);
    tick();
    check_eq("cp_ack_fall", {7'd0, ACK}, 8'd0);
    tick(); tick();

    // Clockport write
    A = 8'h10; RW = 1'b0; DIN = 8'h77; set_req(4'b1000);
    tick(); tick(); tick();
    check_eq("cpw_req", {7'd0, CP_REQ}, 8'd1);
    check_eq("cpw_rw", {7'd0, CP_RW}, 8'd0);
    check_eq("cpw_wdata", CP_WDATA, 8'h77);
    check_eq("cpw_addr", CP_ADDR, 8'h10);
    CP_DONE = 1'b1; CP_RDATA = 8'hEE;
    tick();
    CP_DONE = 1'b0;
    check_eq("cpw_doe", {7'd0, DOE}, 8'd0);
    check_eq("cpw_dout", DOUT, 8'h00);
    tick(); tick();
    check_eq("cpw_ack", {7'd0, ACK}, 8'd1);
    set_req(4'd0);
    tick(); tick(); tick();

    // Abort: BTN request dropped in SETUP
    A = 8'h00; RW = 1'b1; set_req(4'b0100);
    tick(); tick(); tick();
    check_eq("abort_doe_setup", {7'd0, DOE}, 8'd1);
    set_req(4'd0);
    tick();
    check_eq("abort_err", {7'd0, ERR}, 8'd1);
    check_eq("abort_ack", {7'd0, ACK}, 8'd0);
    check_eq("abort_doe", {7'd0, DOE}, 8'd0);
    tick();
    check_eq("abort_ack2", {7'd0, ACK}, 8'd0);
    tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check_eq("err_clr", {7'd0, ERR}, 8'd0);

    // Clear wins over a same-cycle abort error
    set_req(4'b0100);
    tick(); tick(); tick();
    set_req(4'd0); ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check_eq("clr_wins", {7'd0, ERR}, 8'd0);
    tick();
    check_eq("clr_wins_ack", {7'd0, ACK}, 8'd0);
    tick();

    // Simultaneous RTC+JOY: RTC wins, ERR set
    do_cycle(4'b0011, 8'h14, 1'b1, 8'h00, 8'h5A, "simul");
    check_eq("simul_err", {7'd0, ERR}, 8'd1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;

    // Reset while waiting on the clockport
    A = 8'h22; RW = 1'b1; set_req(4'b1000);
    tick(); tick(); tick();
    check_eq("rstcp_req_up", {7'd0, CP_REQ}, 8'd1);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("rstcp_req", {7'd0, CP_REQ}, 8'd0);
    set_req(4'd0);
    tick();
    RESET_N = 1'b1;
    tick();

    // Reset while in ACKED, then RTC contents are gone
    A = 8'h14; RW = 1'b1; set_req(4'b0001);
    tick(); tick(); tick(); tick(); tick();
    check_eq("rst_acked_up", {7'd0, ACK}, 8'd1);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("rst_acked_ack", {7'd0, ACK}, 8'd0);
    check_eq("rst_acked_doe", {7'd0, DOE}, 8'd0);
    check_eq("rst_acked_cpreq", {7'd0, CP_REQ}, 8'd0);
    check_eq("rst_acked_dout", DOUT, 8'h00);
    set_req(4'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    do_cycle(4'b0001, 8'h14, 1'b1, 8'h00, 8'h00, "rtc_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
